// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control-word definitions: op-word table, ALU function codes and decode helper.
// The producer-side encoder uses this same package, so both ends of the interface share one table.
package alu_ctrl_pkg;

  localparam int OP_W       = 8;
  localparam int ALU_CODE_W = 4;

  typedef enum logic [ALU_CODE_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_MUL  = 4'd10,
    ALU_NOT  = 4'd11,
    ALU_NOP  = 4'd12
  } alu_code_e;

  localparam logic [OP_W-1:0] OP_ADD  = 8'h18;
  localparam logic [OP_W-1:0] OP_SUB  = 8'h20;
  localparam logic [OP_W-1:0] OP_AND  = 8'h50;
  localparam logic [OP_W-1:0] OP_OR   = 8'h6A;
  localparam logic [OP_W-1:0] OP_XOR  = 8'h7A;
  localparam logic [OP_W-1:0] OP_SLL  = 8'h8A;
  localparam logic [OP_W-1:0] OP_SRL  = 8'h9A;
  localparam logic [OP_W-1:0] OP_SRA  = 8'hAA;
  localparam logic [OP_W-1:0] OP_SLT  = 8'hBA;
  localparam logic [OP_W-1:0] OP_SLTU = 8'hCA;
  localparam logic [OP_W-1:0] OP_MUL  = 8'hDA;
  localparam logic [OP_W-1:0] OP_NOT  = 8'hE0;
  localparam logic [OP_W-1:0] OP_NOP  = 8'hFF;

  typedef struct packed {
    logic                  legal;
    logic [ALU_CODE_W-1:0] code;
  } dec_t;

  // Any word outside the table decodes as illegal with a zero code.
  function automatic dec_t decode_op(input logic [OP_W-1:0] op);
    dec_t d;
    d.legal = 1'b1;
    d.code  = '0;
    case (op)
      OP_ADD:  d.code = ALU_ADD;
      OP_SUB:  d.code = ALU_SUB;
      OP_AND:  d.code = ALU_AND;
      OP_OR:   d.code = ALU_OR;
      OP_XOR:  d.code = ALU_XOR;
      OP_SLL:  d.code = ALU_SLL;
      OP_SRL:  d.code = ALU_SRL;
      OP_SRA:  d.code = ALU_SRA;
      OP_SLT:  d.code = ALU_SLT;
      OP_SLTU: d.code = ALU_SLTU;
      OP_MUL:  d.code = ALU_MUL;
      OP_NOT:  d.code = ALU_NOT;
      OP_NOP:  d.code = ALU_NOP;
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_op_decoder_sync_fifo.sv
// Small synchronous FIFO: register storage, wrapping pointers and an occupancy count
// one bit wider than the pointers so full and empty never alias.
module sync_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [AW:0]      count_reg, count_next;
  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic             do_push, do_pop;

  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_reg[rd_ptr_reg];

  // Entries are cleared on reset so the head reads zero straight out of reset.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          mem_reg[gi] <= '0;
        end else if (do_push && (wr_ptr_reg == AW'(gi))) begin
          mem_reg[gi] <= wdata;
        end
      end
    end
  endgenerate

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (do_push) begin
      wr_ptr_next = wr_ptr_reg + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_next = rd_ptr_reg + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + (AW+1)'(1);
      2'b01:   count_next = count_reg - (AW+1)'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

endmodule

// File: rtl/alu_op_decoder.sv
// Receiving end of the ALU control-word link: decodes op words on acceptance, buffers
// legal function codes for the ALU issue stage, and drops/counts illegal words.
module alu_op_decoder
  import alu_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ERR_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic [OP_W-1:0]       op,
  output logic                  alu_valid,
  input  logic                  alu_ready,
  output logic [ALU_CODE_W-1:0] alu,
  output logic                  illegal,
  output logic [ERR_W-1:0]      err_cnt,
  input  logic                  clr_err
);

  dec_t             dec;
  logic             full, empty;
  logic             accept, push, pop;
  logic             illegal_reg, illegal_next;
  logic [ERR_W-1:0] err_cnt_reg, err_cnt_next;

  assign dec       = decode_op(op);
  assign op_ready  = !full;
  assign alu_valid = !empty;
  assign accept    = op_valid && op_ready;
  assign push      = accept && dec.legal;
  assign pop       = alu_valid && alu_ready;

  sync_fifo #(
    .WIDTH (ALU_CODE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (dec.code),
    .pop   (pop),
    .rdata (alu),
    .full  (full),
    .empty (empty)
  );

  // A clear in the same cycle as an illegal acceptance wins over the increment.
  always_comb begin
    illegal_next = illegal_reg;
    err_cnt_next = err_cnt_reg;
    if (clr_err) begin
      illegal_next = 1'b0;
      err_cnt_next = '0;
    end else if (accept && !dec.legal) begin
      illegal_next = 1'b1;
      if (err_cnt_reg != {ERR_W{1'b1}}) begin
        err_cnt_next = err_cnt_reg + ERR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_reg <= 1'b0;
      err_cnt_reg <= '0;
    end else begin
      illegal_reg <= illegal_next;
      err_cnt_reg <= err_cnt_next;
    end
  end

  assign illegal = illegal_reg;
  assign err_cnt = err_cnt_reg;

endmodule

// File: tb/tb_alu_op_decoder.sv
// Directed bench for alu_op_decoder: queue-based reference model checked every cycle,
// plus hand-computed expectations; a second instance with ERR_W=2 covers saturation.
module tb_alu_op_decoder;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       op_valid = 1'b0;
  logic [7:0] op = 8'h00;
  logic       alu_ready = 1'b0;
  logic       clr_err = 1'b0;

  logic       op_ready, alu_valid, illegal;
  logic [3:0] alu;
  logic [7:0] err_cnt;
  logic       op_ready_s, alu_valid_s, illegal_s;
  logic [3:0] alu_s;
  logic [1:0] err_cnt_s;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int code_of[int];
  int mq[$];
  int m_err, m_err_s;
  bit m_ill;

  always #5 clk = ~clk;

  alu_op_decoder #(.DEPTH(DEPTH), .ERR_W(8)) u_dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready), .op(op),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu(alu),
    .illegal(illegal), .err_cnt(err_cnt), .clr_err(clr_err)
  );

  alu_op_decoder #(.DEPTH(DEPTH), .ERR_W(2)) u_dut_sat (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready_s), .op(op),
    .alu_valid(alu_valid_s), .alu_ready(alu_ready), .alu(alu_s),
    .illegal(illegal_s), .err_cnt(err_cnt_s), .clr_err(clr_err)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Model: advance on each edge from its own queue and the driven inputs only.
  initial begin
    int n;
    bit rdy;
    code_of[8'h18] = 0;  code_of[8'h20] = 1;  code_of[8'h50] = 2;  code_of[8'h6A] = 3;
    code_of[8'h7A] = 4;  code_of[8'h8A] = 5;  code_of[8'h9A] = 6;  code_of[8'hAA] = 7;
    code_of[8'hBA] = 8;  code_of[8'hCA] = 9;  code_of[8'hDA] = 10; code_of[8'hE0] = 11;
    code_of[8'hFF] = 12;
    m_err = 0; m_err_s = 0; m_ill = 1'b0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mq.delete();
        m_err = 0; m_err_s = 0; m_ill = 1'b0;
      end else begin
        n = mq.size();
        rdy = (n < DEPTH);
        if (n > 0 && alu_ready) void'(mq.pop_front());
        if (op_valid && rdy) begin
          if (code_of.exists(int'(op))) mq.push_back(code_of[int'(op)]);
          else begin
            m_ill = 1'b1;
            if (m_err < 255) m_err++;
            if (m_err_s < 3) m_err_s++;
          end
        end
        if (clr_err) begin
          m_ill = 1'b0; m_err = 0; m_err_s = 0;
        end
      end
    end
  end

  // Compare process on the falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("op_ready", int'(op_ready), int'(mq.size() < DEPTH));
      chk("alu_valid", int'(alu_valid), int'(mq.size() != 0));
      if (mq.size() != 0) chk("alu", int'(alu), mq[0]);
      chk("illegal", int'(illegal), int'(m_ill));
      chk("err_cnt", int'(err_cnt), m_err);
      chk("op_ready_s", int'(op_ready_s), int'(mq.size() < DEPTH));
      chk("alu_valid_s", int'(alu_valid_s), int'(mq.size() != 0));
      if (mq.size() != 0) chk("alu_s", int'(alu_s), mq[0]);
      chk("illegal_s", int'(illegal_s), int'(m_ill));
      chk("err_cnt_s", int'(err_cnt_s), m_err_s);
    end
  end

  initial begin
    int exp_codes[4];
    int popped;
    exp_codes = '{0, 1, 2, 12};

    // Reset state
    step(); step();
    chk("rst_op_ready", int'(op_ready), 1);
    chk("rst_alu_valid", int'(alu_valid), 0);
    chk("rst_alu", int'(alu), 0);
    chk("rst_illegal", int'(illegal), 0);
    chk("rst_err_cnt", int'(err_cnt), 0);
    rst = 1'b0;
    step();
    $display("reset released");

    // Single word 0x6A -> code 3, one cycle latency
    op_valid = 1'b1; op = 8'h6A; alu_ready = 1'b1;
    step();
    op_valid = 1'b0;
    chk("t1_valid", int'(alu_valid), 1);
    chk("t1_alu", int'(alu), 3);
    step();
    chk("t1_drained", int'(alu_valid), 0);
    $display("txn push 0x6A -> alu=3");

    // Fill to full with alu_ready low, then drain in order
    alu_ready = 1'b0;
    op_valid = 1'b1;
    op = 8'h18; step();
    op = 8'h20; step();
    op = 8'h50; step();
    op = 8'hFF; step();
    op_valid = 1'b0;
    chk("t2_full_ready", int'(op_ready), 0);
    alu_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t2_order", int'(alu), exp_codes[i]);
      step();
      if (i == 0) chk("t2_ready_back", int'(op_ready), 1);
      $display("txn drain code %0d", exp_codes[i]);
    end
    chk("t2_empty", int'(alu_valid), 0);

    // Illegal words interleaved with a legal one
    alu_ready = 1'b0;
    op_valid = 1'b1;
    op = 8'h00; step();
    op = 8'h7A; step();
    op = 8'h19; step();
    op_valid = 1'b0;
    chk("t3_illegal", int'(illegal), 1);
    chk("t3_err_cnt", int'(err_cnt), 2);
    chk("t3_alu", int'(alu), 4);
    alu_ready = 1'b1;
    step();
    chk("t3_only_one", int'(alu_valid), 0);
    clr_err = 1'b1; step(); clr_err = 1'b0;
    chk("t3_clr_illegal", int'(illegal), 0);
    chk("t3_clr_err", int'(err_cnt), 0);
    $display("txn illegal pair counted and cleared");

    // Clear coinciding with an illegal acceptance
    op_valid = 1'b1; op = 8'h33; clr_err = 1'b1;
    step();
    op_valid = 1'b0; clr_err = 1'b0;
    chk("t3b_clr_wins_ill", int'(illegal), 0);
    chk("t3b_clr_wins_cnt", int'(err_cnt), 0);
    $display("txn clear beats illegal");

    // Saturation on the 2-bit counter instance
    op_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      op = 8'(i);
      step();
    end
    op_valid = 1'b0;
    chk("t4_sat", int'(err_cnt_s), 3);
    chk("t4_nosat", int'(err_cnt), 5);
    $display("txn five illegal words, err_cnt=%0d err_cnt_s=%0d", err_cnt, err_cnt_s);

    // Half full, then streaming push and pop together
    alu_ready = 1'b0;
    op_valid = 1'b1; op = 8'h8A;
    step(); step();
    alu_ready = 1'b1;
    popped = 0;
    for (int i = 0; i < 10; i++) begin
      chk("t5_alu", int'(alu), 5);
      if (alu_valid && alu_ready) popped++;
      step();
      chk("t5_ready", int'(op_ready), 1);
    end
    op_valid = 1'b0;
    chk("t5_popped", popped, 10);
    step(); step();
    chk("t5_drained", int'(alu_valid), 0);
    $display("txn streamed %0d codes of 5", popped);

    // Asynchronous reset with entries buffered
    alu_ready = 1'b0;
    op_valid = 1'b1;
    op = 8'h18; step();
    op = 8'h20; step();
    op = 8'h50; step();
    op_valid = 1'b0;
    chk("t6_pre_valid", int'(alu_valid), 1);
    #1 rst = 1'b1;
    #1;
    chk("t6_async_valid", int'(alu_valid), 0);
    chk("t6_async_ready", int'(op_ready), 1);
    step();
    rst = 1'b0;
    alu_ready = 1'b1;
    step();
    chk("t6_no_stale", int'(alu_valid), 0);
    step();
    chk("t6_no_stale2", int'(alu_valid), 0);
    op_valid = 1'b1; op = 8'h20;
    step();
    op_valid = 1'b0;
    chk("t6_fresh_valid", int'(alu_valid), 1);
    chk("t6_fresh_alu", int'(alu), 1);
    step();
    $display("txn async reset flushed buffered words");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
